// File: rtl/pc_gen.sv
// Fetch program-counter generator: a valid/ready request stream with prioritised trap/branch redirects.
// Optional compressed-instruction support (2-byte step and alignment) is enabled by defining PC_GEN_RVC_EN.
module pc_gen #(
    parameter int unsigned           XLEN         = 64,
    parameter logic [XLEN-1:0]       RESET_VECTOR = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_br_valid,
    input  logic [XLEN-1:0] i_br_pc,
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_pc,
`ifdef PC_GEN_RVC_EN
    input  logic            i_is_c,
`endif
    output logic            o_req_valid,
    input  logic            i_req_ready,
    output logic [XLEN-1:0] o_pc,
    output logic            o_redirect,
    output logic            o_misalign,
    output logic [XLEN-1:0] o_misalign_pc
);

`ifdef PC_GEN_RVC_EN
    localparam int unsigned ALIGN_BITS = 1;
`else
    localparam int unsigned ALIGN_BITS = 2;
`endif
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((1 << ALIGN_BITS) - 1);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t          state;
    logic            fire;
    logic            br_misaligned;
    logic [XLEN-1:0] step;

    assign o_req_valid   = (state == RUN) && !i_stall;
    assign fire          = o_req_valid && i_req_ready;
    assign br_misaligned = (i_br_pc & ALIGN_MASK) != '0;

    always_comb begin
`ifdef PC_GEN_RVC_EN
        step = i_is_c ? XLEN'(2) : XLEN'(4);
`else
        step = XLEN'(4);
`endif
    end

    // Redirects take precedence over a same-cycle fire; the fetched data is flushed by o_redirect.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= BOOT;
            o_pc          <= RESET_VECTOR;
            o_redirect    <= 1'b0;
            o_misalign    <= 1'b0;
            o_misalign_pc <= '0;
        end else begin
            o_redirect <= 1'b0;
            if (state == BOOT)
                state <= RUN;

            if (i_trap_valid) begin
                o_pc       <= i_trap_pc & ~ALIGN_MASK;
                state      <= RUN;
                o_misalign <= 1'b0;
                o_redirect <= 1'b1;
            end else if (state == RUN && i_br_valid) begin
                o_redirect <= 1'b1;
                if (br_misaligned) begin
                    state         <= FAULT;
                    o_misalign    <= 1'b1;
                    o_misalign_pc <= i_br_pc;
                end else begin
                    o_pc <= i_br_pc;
                end
            end else if (fire) begin
                o_pc <= o_pc + step;
            end
        end
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised fetch program-counter generator. It is the successor to the fixed 64-bit PC register and adds a configurable width and reset vector, a valid/ready fetch-request handshake, prioritised trap and branch redirects, and trapping of misaligned branch targets. It sits at the head of the IF stage and drives instruction-memory requests and the fetch-queue flush.

Parameters:
- XLEN, 64, address width in bits; legal values are 32 and 64.
- RESET_VECTOR, 0, PC value loaded on reset; must be aligned to the instruction alignment (IALIGN).

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_stall  input  1  fetch-queue back-pressure; while high, no new requests are issued.
- i_br_valid  input  1  branch/jump redirect from EX.
- i_br_pc  input  XLEN  branch target.
- i_trap_valid  input  1  trap/mret redirect from CSR.
- i_trap_pc  input  XLEN  trap target; low alignment bits are ignored (forced to 0).
- o_req_valid  output  1  fetch request valid.
- i_req_ready  input  1  instruction memory accepts the request.
- o_pc  output  XLEN  current fetch address.
- o_redirect  output  1  one-cycle pulse; flush the fetch queue.
- o_misalign  output  1  misaligned branch target fault is pending.
- o_misalign_pc  output  XLEN  the offending branch target.

Behaviour:
- Reset: one clock, synchronous reset, active-high (i_rst); takes priority over every other input in the same cycle.
- Reset values: o_pc=RESET_VECTOR, state=BOOT, o_req_valid=0, o_redirect=0, o_misalign=0, o_misalign_pc=0.
- Reset asserted mid-operation: the same values apply on the next edge, regardless of outstanding handshakes or a pending fault.
- States:
  - BOOT: lasts exactly one cycle, then moves to RUN.
  - RUN: normal fetch.
  - FAULT: misaligned-target fault held.
- o_req_valid = (state==RUN) && !i_stall. It is combinational from the state register and i_stall.
- fire = o_req_valid && i_req_ready.
- Alignment (IALIGN) is 4 bytes: a target is misaligned if target[1:0] != 0. Step is 4.
- Next-PC priority per cycle, highest first:
  1. Trap: valid in any state. o_pc <= {i_trap_pc[XLEN-1:2], 2'b00}; state <= RUN; o_misalign <= 0; o_redirect <= 1.
  2. Branch, RUN only, aligned target: o_pc <= i_br_pc; o_redirect <= 1.
  3. Branch, RUN only, misaligned target: o_pc holds; state <= FAULT; o_misalign <= 1; o_misalign_pc <= i_br_pc; o_redirect <= 1.
  4. Fire with no redirect: o_pc <= o_pc + step, wrapping modulo 2^XLEN (e.g. all-ones minus 3 wraps to 0).
  5. Otherwise: o_pc holds.
- Redirects override the handshake. A request that fires in the same cycle as a redirect is still counted as issued; its data is flushed by o_redirect.
- o_pc is stable while o_req_valid && !i_req_ready, unless a redirect occurs.
- i_stall does not block redirects. A redirect taken while stalled loads the PC, and the request issues once the stall drops.
- Branches are ignored in BOOT and FAULT.
- FAULT is exited only by a trap or by reset. o_misalign and o_misalign_pc hold until then.
- o_redirect is registered and high for exactly one cycle per accepted redirect. Back-to-back redirects give back-to-back pulses.
- Arithmetic uses XLEN bits only, with no carry out. o_pc is never X after reset.

Optional Feature:
- Macro: PC_GEN_RVC_EN.
- Defined (compressed support):
  - Extra input i_is_c (1 bit) is sampled on fire; step = i_is_c ? 2 : 4.
  - IALIGN becomes 2: misaligned means target[0] != 0, and trap targets force only bit 0 to zero.
- Undefined:
  - The i_is_c port does not exist; step is always 4 and IALIGN is 4 as described above.

Test Plan:
- Reset with RESET_VECTOR=0x8000_0000, then hold i_req_ready=1 for 4 cycles. Required:
  - o_req_valid=0 in the BOOT cycle.
  - o_pc sequence 0x80000000, 0x80000004, 0x80000008, 0x8000000C.
  - o_redirect=0 throughout.
- Back-pressure: with i_req_ready=0 for 3 cycles, o_pc holds at 0x...04 with o_req_valid=1. With i_stall=1, o_req_valid=0 and o_pc holds.
- Simultaneous i_trap_valid (target 0x100) and i_br_valid (target 0x200) during a fire. Required: next o_pc=0x100, one o_redirect pulse, and no +4.
- Branch to 0x202: state goes to FAULT with o_misalign=1, o_misalign_pc=0x202 and o_req_valid=0. A later branch is ignored. A trap to 0x303 gives o_pc=0x300, o_misalign=0 and RUN.
- o_pc=0xFFFF_FFFF_FFFF_FFFC with one fire. Required: o_pc=0. Reset asserted while in FAULT returns all outputs to their reset values.
- With PC_GEN_RVC_EN defined: fires with i_is_c=1,0,1 from 0x0 give o_pc 0x2, 0x6, 0x8. A branch to 0x202 is accepted; a branch to 0x201 faults.
